// File: rtl/aqp_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aqp_sram_ctrl_if
//  Description : Core-side request/response bus for the external SRAM
//                controller. The master drives a request, holds it stable
//                and waits for the one-cycle ack. The slave returns read
//                data together with that ack.
//  Signals     : bus_addr     byte address (ADDR_WIDTH)
//                bus_wrdata   write data, lane i = [8i+7:8i]
//                bus_bytesel  lane enables (BYTES)
//                bus_wren     1 = write, 0 = read
//                bus_strobe   request, held until bus_ack
//                bus_rddata   read data, valid with bus_ack
//                bus_ack      one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface aqp_sram_ctrl_if #(
    parameter int BYTES      = 4,
    parameter int ADDR_WIDTH = 19
);
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [8*BYTES-1:0]    bus_wrdata;
    logic [BYTES-1:0]      bus_bytesel;
    logic                  bus_wren;
    logic                  bus_strobe;
    logic [8*BYTES-1:0]    bus_rddata;
    logic                  bus_ack;

    modport master (
        output bus_addr, bus_wrdata, bus_bytesel, bus_wren, bus_strobe,
        input  bus_rddata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wrdata, bus_bytesel, bus_wren, bus_strobe,
        output bus_rddata, bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/aqp_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aqp_sram_ctrl
//  Description : Controller for the external byte-wide SRAM on the ebus.
//                Splits one multi-byte core request into a sequence of
//                byte accesses of ACCESS_CYCLES clocks each. Writes add one
//                recovery clock per byte with we_n high. Unselected lanes
//                are skipped and read back as zero. All outputs are
//                registered. The ebus_d tristate is owned by the top level.
//  Ports       : clk, reset_n  clock, synchronous active-low reset
//                bus           aqp_sram_ctrl_if.slave core request bus
//                ram_a         SRAM address (19 bits)
//                ram_ce_n/oe_n/we_n  SRAM strobes
//                ram_d_out     write byte to pins
//                ram_d_oe      1 = FPGA drives ebus_d
//                ram_d_in      byte from pins
//  Options     : AQP_SRAM_RDBUF_EN - single-entry read buffer holding the
//                last fully read word; covered reads are answered without
//                SRAM cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module aqp_sram_ctrl #(
    parameter int BYTES         = 4,
    parameter int ADDR_WIDTH    = 19,
    parameter int ACCESS_CYCLES = 2
) (
    input  wire             clk,
    input  wire             reset_n,
    aqp_sram_ctrl_if.slave  bus,
    output logic [18:0]     ram_a,
    output logic            ram_ce_n,
    output logic            ram_oe_n,
    output logic            ram_we_n,
    output logic [7:0]      ram_d_out,
    output logic            ram_d_oe,
    input  wire  [7:0]      ram_d_in
);

    localparam int         LANE_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [3:0] C_LAST_CNT = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Lowest set lane of a mask (0 when the mask is empty).
    function automatic logic [LANE_W-1:0] f_lowest(input logic [BYTES-1:0] mask);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (mask[i]) idx = LANE_W'(i);
        end
        return idx;
    endfunction

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
    logic [8*BYTES-1:0]    r_wdata, w_wdata_nxt;
    logic                  r_wren, w_wren_nxt;
    logic [BYTES-1:0]      r_pend, w_pend_nxt;     // lanes not yet started
    logic [LANE_W-1:0]     r_lane, w_lane_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_ram_a, w_ram_a_nxt;
    logic                  r_ce_n, w_ce_n_nxt;
    logic                  r_oe_n, w_oe_n_nxt;
    logic                  r_we_n, w_we_n_nxt;
    logic [7:0]            r_d_out, w_d_out_nxt;
    logic                  r_d_oe, w_d_oe_nxt;
    logic [8*BYTES-1:0]    r_rddata, w_rddata_nxt;
    logic                  r_ack, w_ack_nxt;

    logic                  w_go;        // start the lowest lane of w_go_mask
    logic                  w_finish;    // move to DONE with strobes released
    logic [BYTES-1:0]      w_go_mask;
    logic [ADDR_WIDTH-1:0] w_go_base;
    logic [8*BYTES-1:0]    w_go_wdata;
    logic                  w_go_wren;
    logic [LANE_W-1:0]     w_go_lane;

    logic [ADDR_WIDTH-1:0] w_req_base;
    logic                  w_hit;
    logic [8*BYTES-1:0]    w_buf_rd;

    // Word-aligned base; the low lane bits of the request address are ignored.
    assign w_req_base = bus.bus_addr & ~ADDR_WIDTH'(BYTES - 1);

`ifdef AQP_SRAM_RDBUF_EN
    logic                  r_buf_valid;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [8*BYTES-1:0]    r_buf_data;
    logic                  r_full;
    logic [8*BYTES-1:0]    w_sel_bits;
    logic                  w_accept;
    logic                  w_fill;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_sel_bits
        assign w_sel_bits[8*gi +: 8] = {8{bus.bus_bytesel[gi]}};
    end

    assign w_accept = (r_state == S_IDLE) && bus.bus_strobe && !r_ack;
    // Last byte of a read that covered every lane completes the buffer word.
    assign w_fill   = (r_state == S_ACCESS) && (r_cnt == C_LAST_CNT) && !r_wren
                      && (r_pend == '0) && r_full;
    assign w_hit    = r_buf_valid && !bus.bus_wren && (w_req_base == r_buf_addr);
    assign w_buf_rd = r_buf_data & w_sel_bits;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_full      <= 1'b0;
        end else begin
            if (w_accept) r_full <= &bus.bus_bytesel;
            if (w_fill) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= r_base;
                r_buf_data  <= w_rddata_nxt;
            end else if (w_accept && bus.bus_wren && r_buf_valid
                         && (w_req_base == r_buf_addr)) begin
                // Keep the buffered copy coherent with the write.
                r_buf_data <= (r_buf_data & ~w_sel_bits) | (bus.bus_wrdata & w_sel_bits);
            end
        end
    end
`else
    assign w_hit    = 1'b0;
    assign w_buf_rd = '0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_wdata_nxt  = r_wdata;
        w_wren_nxt   = r_wren;
        w_pend_nxt   = r_pend;
        w_lane_nxt   = r_lane;
        w_cnt_nxt    = r_cnt;
        w_ram_a_nxt  = r_ram_a;
        w_ce_n_nxt   = r_ce_n;
        w_oe_n_nxt   = r_oe_n;
        w_we_n_nxt   = r_we_n;
        w_d_out_nxt  = r_d_out;
        w_d_oe_nxt   = r_d_oe;
        w_rddata_nxt = r_rddata;
        w_ack_nxt    = 1'b0;
        w_go         = 1'b0;
        w_finish     = 1'b0;
        w_go_mask    = r_pend;
        w_go_base    = r_base;
        w_go_wdata   = r_wdata;
        w_go_wren    = r_wren;

        case (r_state)
            S_IDLE: begin
                if (bus.bus_strobe && !r_ack) begin
                    w_base_nxt   = w_req_base;
                    w_wdata_nxt  = bus.bus_wrdata;
                    w_wren_nxt   = bus.bus_wren;
                    w_rddata_nxt = w_hit ? w_buf_rd : '0;
                    if ((bus.bus_bytesel == '0) || w_hit) begin
                        w_finish = 1'b1;
                    end else begin
                        w_go       = 1'b1;
                        w_go_mask  = bus.bus_bytesel;
                        w_go_base  = w_req_base;
                        w_go_wdata = bus.bus_wrdata;
                        w_go_wren  = bus.bus_wren;
                    end
                end
            end
            S_ACCESS: begin
                if (r_cnt == C_LAST_CNT) begin
                    if (r_wren) begin
                        // Raise we_n but keep address, data and ce for hold time.
                        w_state_nxt = S_RECOVER;
                        w_we_n_nxt  = 1'b1;
                    end else begin
                        w_rddata_nxt[8*r_lane +: 8] = ram_d_in;
                        if (r_pend != '0) w_go = 1'b1;
                        else              w_finish = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_RECOVER: begin
                if (r_pend != '0) w_go = 1'b1;
                else              w_finish = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_go_lane = f_lowest(w_go_mask);

        if (w_go) begin
            w_state_nxt = S_ACCESS;
            w_lane_nxt  = w_go_lane;
            w_pend_nxt  = w_go_mask & ~(BYTES'(1) << w_go_lane);
            w_cnt_nxt   = 4'd0;
            w_ram_a_nxt = w_go_base + ADDR_WIDTH'(w_go_lane);
            w_ce_n_nxt  = 1'b0;
            w_oe_n_nxt  = w_go_wren;
            w_we_n_nxt  = !w_go_wren;
            w_d_oe_nxt  = w_go_wren;
            w_d_out_nxt = w_go_wren ? w_go_wdata[8*w_go_lane +: 8] : r_d_out;
        end

        if (w_finish) begin
            w_state_nxt = S_DONE;
            w_ack_nxt   = 1'b1;
            w_ce_n_nxt  = 1'b1;
            w_oe_n_nxt  = 1'b1;
            w_we_n_nxt  = 1'b1;
            w_d_oe_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_wdata  <= '0;
            r_wren   <= 1'b0;
            r_pend   <= '0;
            r_lane   <= '0;
            r_cnt    <= 4'd0;
            r_ram_a  <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_d_out  <= 8'd0;
            r_d_oe   <= 1'b0;
            r_rddata <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_base   <= w_base_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wren   <= w_wren_nxt;
            r_pend   <= w_pend_nxt;
            r_lane   <= w_lane_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ram_a  <= w_ram_a_nxt;
            r_ce_n   <= w_ce_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_we_n   <= w_we_n_nxt;
            r_d_out  <= w_d_out_nxt;
            r_d_oe   <= w_d_oe_nxt;
            r_rddata <= w_rddata_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    // Fit the internal address onto the 19 SRAM address pins.
    if (ADDR_WIDTH >= 19) begin : g_addr_trunc
        assign ram_a = r_ram_a[18:0];
    end else begin : g_addr_ext
        assign ram_a = {{(19 - ADDR_WIDTH){1'b0}}, r_ram_a};
    end

    assign ram_ce_n        = r_ce_n;
    assign ram_oe_n        = r_oe_n;
    assign ram_we_n        = r_we_n;
    assign ram_d_out       = r_d_out;
    assign ram_d_oe        = r_d_oe;
    assign bus.bus_rddata  = r_rddata;
    assign bus.bus_ack     = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_aqp_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aqp_sram_ctrl
//  Description : Self-checking bench for aqp_sram_ctrl. Requests are issued
//                through the bus interface; the expected response of each
//                is pushed into a scoreboard queue and a monitor compares it
//                when bus_ack appears. A byte-array SRAM model sits on the
//                pins. Honours AQP_SRAM_RDBUF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aqp_sram_ctrl;
    localparam int BYTES = 4;
    localparam int AW    = 19;
    localparam int AC    = 2;
    localparam int AMASK = 32'h7FFFF;
`ifdef AQP_SRAM_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [18:0] ram_a;
    logic        ram_ce_n, ram_oe_n, ram_we_n, ram_d_oe;
    logic [7:0]  ram_d_out, ram_d_in;

    always #5 clk = ~clk;

    aqp_sram_ctrl_if #(.BYTES(BYTES), .ADDR_WIDTH(AW)) bus ();

    aqp_sram_ctrl #(.BYTES(BYTES), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .ram_a     (ram_a),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_d_out (ram_d_out),
        .ram_d_oe  (ram_d_oe),
        .ram_d_in  (ram_d_in)
    );

    // Pin-level SRAM model
    logic [7:0] sram [0:524287];
    initial for (int i = 0; i < 524288; i++) sram[i] = 8'(i) ^ 8'h3C;
    always @(posedge clk) if (!ram_ce_n && !ram_we_n) sram[ram_a] <= ram_d_out;
    assign ram_d_in = (!ram_ce_n && !ram_oe_n) ? sram[ram_a] : 8'hA5;

    // Reference memory: sparse, seeded with the same power-on pattern
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'(a) ^ 8'h3C;
    endfunction

    typedef struct {
        string       name;
        bit          rd;
        int          base;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] data;
        int          cyc;
        int          ce;
        int          we_low;
        int          pulses;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   mb_valid = 1'b0;
    int   mb_addr  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    // Monitor: protocol counters plus scoreboard comparison on every ack
    int   ce_cnt = 0, we_cnt = 0, pul_cnt = 0, viol = 0, wl = 0, ln = 0;
    logic prev_we = 1'b1;
    exp_t e;
    always @(negedge clk) begin
        if (!ram_oe_n && !ram_we_n) viol++;
        if (!ram_oe_n && ram_d_oe)  viol++;
        if (!reset_n) begin
            ce_cnt = 0; we_cnt = 0; pul_cnt = 0; wl = 0;
        end else begin
            if (!ram_ce_n) ce_cnt++;
            if (!ram_we_n) we_cnt++;
            if (!ram_we_n && prev_we && q.size() > 0 && !q[0].rd) begin
                pul_cnt++;
                ln = -1;
                for (int i = 3; i >= wl; i--) if (q[0].sel[i]) ln = i;
                if (ln < 0) begin
                    chk({q[0].name, ".extra_we"}, 32'(pul_cnt), 32'(q[0].pulses));
                end else begin
                    chk({q[0].name, ".wr_addr"}, 32'(ram_a), (q[0].base + ln) & AMASK);
                    chk({q[0].name, ".wr_byte"}, 32'(ram_d_out), 32'(q[0].wdata[8*ln +: 8]));
                    wl = ln + 1;
                end
            end
        end
        prev_we = ram_we_n;
        if (bus.bus_ack) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk({e.name, ".latency_cyc"}, 32'(cyc), 32'(e.cyc));
                if (e.rd) chk({e.name, ".rddata"}, bus.bus_rddata, e.data);
                chk({e.name, ".ce_cycles"}, 32'(ce_cnt), 32'(e.ce));
                chk({e.name, ".we_cycles"}, 32'(we_cnt), 32'(e.we_low));
                chk({e.name, ".we_pulses"}, 32'(pul_cnt), 32'(e.pulses));
            end
            ce_cnt = 0; we_cnt = 0; pul_cnt = 0; wl = 0;
        end
    end

    // Driver: computes the expected outcome, queues it, then runs the request
    task automatic issue(input string nm, input int addr, input logic [31:0] data,
                         input logic [3:0] sel, input bit wr);
        exp_t x;
        int   n, lat;
        bit   got;
        x.name = nm; x.rd = !wr; x.sel = sel; x.wdata = data;
        x.base = addr & AMASK & ~3;
        x.data = 32'd0; x.we_low = 0; x.pulses = 0;
        n = $countones(sel);
        if (!wr) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) x.data[8*i +: 8] = ref_rd((x.base + i) & AMASK);
            if (n == 0 || (RDBUF && mb_valid && mb_addr == x.base)) begin
                lat = 1; x.ce = 0;
            end else begin
                lat = 1 + n * AC; x.ce = n * AC;
                if (sel == 4'hF) begin mb_valid = 1'b1; mb_addr = x.base; end
            end
        end else begin
            lat = 1 + n * (AC + 1); x.ce = n * (AC + 1);
            x.we_low = n * AC; x.pulses = n;
            for (int i = 0; i < 4; i++)
                if (sel[i]) ref_mem[(x.base + i) & AMASK] = data[8*i +: 8];
        end
        @(negedge clk);
        x.cyc = cyc + lat;
        q.push_back(x);
        bus.bus_addr    = AW'(addr);
        bus.bus_wrdata  = data;
        bus.bus_bytesel = sel;
        bus.bus_wren    = wr;
        bus.bus_strobe  = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.bus_ack) begin got = 1'b1; break; end
        end
        if (!got) chk({nm, ".ack_timeout"}, 32'd0, 32'd1);
        bus.bus_strobe = 1'b0;
    endtask

    initial begin
        bit found;
        bus.bus_addr = '0; bus.bus_wrdata = '0; bus.bus_bytesel = '0;
        bus.bus_wren = 1'b0; bus.bus_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ce_n",   32'(ram_ce_n),  32'd1);
        chk("rst.oe_n",   32'(ram_oe_n),  32'd1);
        chk("rst.we_n",   32'(ram_we_n),  32'd1);
        chk("rst.d_oe",   32'(ram_d_oe),  32'd0);
        chk("rst.ram_a",  32'(ram_a),     32'd0);
        chk("rst.d_out",  32'(ram_d_out), 32'd0);
        chk("rst.ack",    32'(bus.bus_ack), 32'd0);
        chk("rst.rddata", bus.bus_rddata, 32'd0);
        reset_n = 1'b1;

        issue("wr_deadbeef",  32'h10,    32'hDEADBEEF, 4'hF,    1'b1);
        issue("rd_deadbeef",  32'h10,    32'h0,        4'hF,    1'b0);
        issue("rd_lane2",     32'h12,    32'h0,        4'b0100, 1'b0);
        issue("wr_top_nosel", 32'h7FFFC, 32'h12345678, 4'h0,    1'b1);

        // Reset during the second byte of a write
        @(negedge clk);
        bus.bus_addr = AW'(32'h4000); bus.bus_wrdata = 32'h11223344;
        bus.bus_bytesel = 4'hF; bus.bus_wren = 1'b1; bus.bus_strobe = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!ram_we_n && ram_a == 19'h4001) begin found = 1'b1; break; end
        end
        chk("abort.reached_byte2", 32'(found), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort.we_n", 32'(ram_we_n),    32'd1);
        chk("abort.ce_n", 32'(ram_ce_n),    32'd1);
        chk("abort.d_oe", 32'(ram_d_oe),    32'd0);
        chk("abort.ack",  32'(bus.bus_ack), 32'd0);
        bus.bus_strobe = 1'b0;
        mb_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        issue("rd_after_abort", 32'h10,  32'h0,  4'hF,    1'b0);
        issue("rd100_a",        32'h100, 32'h0,  4'hF,    1'b0);
        issue("rd100_b",        32'h100, 32'h0,  4'hF,    1'b0);
        issue("wr100_lo",       32'h100, 32'h55, 4'b0001, 1'b1);
        issue("rd100_c",        32'h100, 32'h0,  4'hF,    1'b0);

        for (int k = 0; k < 40; k++) begin
            issue($sformatf("rnd%0d", k),
                  32'h200 + 4 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        chk("oe_we_overlap_or_drive_conflict", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
